// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-stage PC controller: state encoding,
// default PC width and the default reset vector.
// Pure declarations, no logic, no flow control.
package cpu_pkg;

  // Encoding 3 is unused and recovers to ST_BOOT in the sequencer.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int          PC_WIDTH     = 32;
  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/pc_incr.sv
// Sequential next-address adder: y = a + 1 modulo 2^WIDTH (wraps silently).
// Latency: combinational. No flow control.
// Ports: a = current word address, y = incremented word address.
module pc_incr #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign y = a + ONE;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: owns the PC and picks increment, branch/jump
// redirect, stall hold or halt each cycle; drives flush and fetch_valid.
// Latency: redirect target on pc one cycle after sampling; flush is same-cycle.
// Backpressure: stall holds the PC (unless a redirect is present); no handshake.
// Ports: clk/rst (async high), stall, br_taken/br_target, jmp/jmp_target,
//        halt, resume in; pc, pc_seq, fetch_valid, flush, state out.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int               WIDTH     = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             halt,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic             fetch_valid,
  output logic             flush,
  output logic [1:0]       state
);

  logic [WIDTH-1:0] pc_q, pc_d;
  state_e           state_q, state_d;
  logic             fetch_valid_q, fetch_valid_d;

  pc_incr #(.WIDTH(WIDTH)) u_pc_incr (
    .a (pc_q),
    .y (pc_seq)
  );

  always_comb begin
    pc_d          = pc_q;
    state_d       = state_q;
    fetch_valid_d = fetch_valid_q;
    case (state_q)
      // One dead cycle after reset: inputs ignored, fetching starts at RESET_VEC.
      ST_BOOT: begin
        state_d       = ST_RUN;
        fetch_valid_d = 1'b1;
      end
      // Branch is the oldest instruction, so it beats jump; any redirect
      // squashes a younger halt and overrides stall.
      ST_RUN: begin
        if (br_taken) begin
          pc_d = br_target;
        end else if (jmp) begin
          pc_d = jmp_target;
        end else if (halt) begin
          state_d       = ST_HALT;
          fetch_valid_d = 1'b0;
        end else if (!stall) begin
          pc_d = pc_seq;
        end
      end
      // An in-flight branch still resolves while halted; resume restarts
      // fetching at the held pc.
      ST_HALT: begin
        fetch_valid_d = 1'b0;
        if (br_taken) begin
          pc_d = br_target;
        end
        if (resume) begin
          state_d       = ST_RUN;
          fetch_valid_d = 1'b1;
        end
      end
      default: begin
        state_d       = ST_BOOT;
        pc_d          = RESET_VEC;
        fetch_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_VEC;
      state_q       <= ST_BOOT;
      fetch_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  // Same-cycle kill so IF/ID clears on the edge that redirects the PC.
  assign flush = !rst && (((state_q == ST_RUN) && (br_taken || jmp)) ||
                          ((state_q == ST_HALT) && br_taken));

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, br_taken, jmp, halt, resume;
  logic [31:0] br_target, jmp_target;
  logic [31:0] pc, pc_seq;
  logic        fetch_valid, flush;
  logic [1:0]  state;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: 0=BOOT, 1=RUN, 2=HALT
  logic [31:0] m_pc;
  int          m_state;
  logic        m_fv;

  pc_sequencer #(.WIDTH(32), .RESET_VEC(RV)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .halt        (halt),
    .resume      (resume),
    .pc          (pc),
    .pc_seq      (pc_seq),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_flush();
    if (rst) return 1'b0;
    if (m_state == 1) return br_taken || jmp;
    if (m_state == 2) return br_taken;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_pc = RV; m_state = 0; m_fv = 1'b0;
  endtask

  // Edge behaviour written straight from the operating rules.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_state == 0) begin
      m_state = 1; m_fv = 1'b1;
    end else if (m_state == 1) begin
      if (br_taken)      m_pc = br_target;
      else if (jmp)      m_pc = jmp_target;
      else if (halt)     begin m_state = 2; m_fv = 1'b0; end
      else if (!stall)   m_pc = m_pc + 32'd1;
    end else begin
      if (br_taken) m_pc = br_target;
      if (resume)   begin m_state = 1; m_fv = 1'b1; end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},     pc,                  m_pc);
    check({tag, ".pc_seq"}, pc_seq,              m_pc + 32'd1);
    check({tag, ".fv"},     {31'd0, fetch_valid}, {31'd0, m_fv});
    check({tag, ".state"},  {30'd0, state},       m_state);
    check({tag, ".flush"},  {31'd0, flush},       {31'd0, model_flush()});
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt,
                       input logic h, input logic r);
    stall = s; br_taken = b; br_target = bt; jmp = j; jmp_target = jt;
    halt = h; resume = r;
  endtask

  // Called at a negedge with inputs already driven: check, clock, update model.
  task automatic tick(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_tick(input string tag);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(tag);
  endtask

  task automatic jump_to(input logic [31:0] a);
    drive(0, 0, 0, 1, a, 0, 0);
    tick("jump_to");
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) tick("reset");
    rst = 1'b0;
    // BOOT cycle, then 0x100, 0x101, 0x102
    idle_tick("boot");
    check("boot_run_pc", pc, 32'h100);
    idle_tick("run0");
    idle_tick("run1");
    check("run_pc_102", pc, 32'h102);
    idle_tick("run2");

    // Stall at 0x20 for 2 cycles
    jump_to(32'h20);
    drive(1, 0, 0, 0, 0, 0, 0); tick("stall0");
    drive(1, 0, 0, 0, 0, 0, 0); tick("stall1");
    check("stall_hold", pc, 32'h20);
    idle_tick("stall_rel");
    check("stall_next", pc, 32'h21);

    // Branch + jump + stall together at 0x40
    jump_to(32'h40);
    drive(1, 1, 32'h80, 1, 32'hC0, 1, 0);
    #1;
    check("simul_flush", {31'd0, flush}, 32'd1);
    tick("simul");
    check("simul_pc", pc, 32'h80);
    idle_tick("simul_after");

    // Halt at 0x10, hold 5 cycles, resume
    jump_to(32'h10);
    drive(0, 0, 0, 0, 0, 1, 0); tick("halt_in");
    for (int i = 0; i < 5; i++) begin
      drive(i[0], 0, 0, i[1], 32'h999, 1, 0);
      tick("halted");
    end
    check("halt_pc", pc, 32'h10);
    check("halt_state", {30'd0, state}, 32'd2);
    drive(0, 0, 0, 0, 0, 0, 1); tick("resume");
    check("resume_state", {30'd0, state}, 32'd1);
    check("resume_pc", pc, 32'h10);
    idle_tick("after_resume");
    check("resume_next", pc, 32'h11);

    // Branch while halted
    drive(0, 0, 0, 0, 0, 1, 0); tick("halt_in2");
    drive(0, 1, 32'h200, 0, 0, 0, 0); tick("halt_branch");
    check("halt_br_pc", pc, 32'h200);
    check("halt_br_fv", {31'd0, fetch_valid}, 32'd0);
    idle_tick("halt_idle");
    drive(0, 0, 0, 0, 0, 0, 1); tick("resume2");

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      logic b, j, h, r, s;
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0);
      j = ($urandom_range(0, 7) == 0);
      h = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 3) == 0) && !b;
      drive(s, b, $urandom, j, $urandom, h, r);
      tick("rand");
    end
    drive(0, 0, 0, 0, 0, 0, 1); tick("rand_exit");

    // Wrap at all-ones
    jump_to(32'hFFFF_FFFF);
    check("wrap_seq", pc_seq, 32'h0);
    idle_tick("wrap");
    check("wrap_pc", pc, 32'h0);

    // Async reset in the middle of a jump cycle
    drive(0, 0, 0, 1, 32'h55, 0, 0);
    #1;
    check("pre_rst_flush", {31'd0, flush}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    tick("rst_hold");
    rst = 1'b0;
    idle_tick("boot2");
    idle_tick("run_after_rst");
    check("post_rst_pc", pc, RV + 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage program-counter controller for the 5-stage pipeline. It owns the PC register and selects each cycle between sequential increment (word-addressed, +1), branch redirect, jump redirect, stall hold and halt. It also drives the IF/ID flush and fetch-valid qualifiers. It sits between the hazard/branch logic (EX, ID) and the instruction memory address port.

## Interface
- WIDTH, 32, PC width in bits (word address)
- RESET_VEC, 32'h0000_0000, PC value loaded on reset
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hazard unit: hold PC this cycle
- br_taken  input  1  EX-stage branch resolved taken
- br_target  input  WIDTH  branch target (word address)
- jmp  input  1  ID-stage jump decoded
- jmp_target  input  WIDTH  jump target (word address)
- halt  input  1  halt instruction decoded in ID
- resume  input  1  external restart request
- pc  output  WIDTH  current fetch address (registered)
- pc_seq  output  WIDTH  pc + 1, combinational, for link/branch-offset use
- fetch_valid  output  1  pc is a real fetch (registered)
- flush  output  1  kill IF/ID contents this cycle (combinational)
- state  output  2  BOOT=0, RUN=1, HALT=2 (registered)

## Operation
- Reset (async, any time, including mid-redirect or mid-halt): pc=RESET_VEC, state=BOOT, fetch_valid=0. Combinational flush=0 while rst is high.
- BOOT: lasts 1 cycle after rst deasserts. Inputs are ignored and pc is unchanged. Next state is RUN with fetch_valid=1.
- RUN, per-edge priority (highest first):
  - br_taken: pc<=br_target, flush=1.
  - jmp: pc<=jmp_target, flush=1.
  - halt: pc held, state<=HALT, fetch_valid<=0.
  - stall: pc held, flush=0.
  - otherwise: pc<=pc_seq.
- Redirect vs. stall: a redirect overrides stall. The redirect is taken in the same cycle; the stall is dropped for that cycle.
- br_taken and jmp together: the branch wins because it is the older instruction. The jump is discarded.
- halt together with br_taken or jmp: the redirect wins, and halt is ignored because it is the flushed instruction.
- HALT:
  - pc is held and fetch_valid=0.
  - br_taken is still honoured: pc<=br_target, state stays HALT, flush=1.
  - jmp, halt and stall are ignored.
  - resume: state<=RUN, fetch_valid<=1, pc unchanged. The next fetch is the held pc.
- resume in BOOT or RUN has no effect.
- Arithmetic: pc_seq = pc + 1 modulo 2^WIDTH. 2^WIDTH−1 wraps to 0 with no error flag.
- Encoding 3 is illegal. It recovers to BOOT on the next edge with pc=RESET_VEC.

## Timing
- pc, fetch_valid and state are registered and change only on the rising clk edge or on async rst.
- flush is combinational from br_taken, jmp, state and rst. It is valid in the same cycle as the redirect, so the IF/ID register clears at the same edge the PC is redirected.
- Redirect latency: target appears on pc 1 cycle after br_taken/jmp is sampled.
- From rst deassert:
  - Edge 1: state=RUN, fetch_valid=1, pc=RESET_VEC.
  - Edge 2: pc=RESET_VEC+1, if no stall.
- HALT entry: fetch_valid falls at the edge that samples halt.
- HALT exit: fetch_valid rises at the edge that samples resume.
- No input handshake. All inputs are single-cycle level pulses sampled every edge.

## Structure
- Shared package cpu_pkg:
  - state enum (BOOT, RUN, HALT)
  - default WIDTH
  - RESET_VEC constant
- Sub-module pc_incr: WIDTH-parameterised +1 adder producing pc_seq, instantiated once.
- Next-pc mux and state register are written inline.

## Test plan
- Reset/boot: assert rst for 3 cycles, RESET_VEC=32'h100 → pc=0x100, fetch_valid=0 during reset and the BOOT cycle. Then pc goes 0x100, 0x101, 0x102 with fetch_valid=1.
- Stall: in RUN at pc=0x20, stall high for 2 cycles → pc stays 0x20 for 2 edges, then 0x21. flush=0 throughout.
- Simultaneous redirect: pc=0x40, br_taken=1 with br_target=0x80, jmp=1 with jmp_target=0xC0, stall=1 → flush=1 that cycle, next pc=0x80.
- Halt/resume: halt at pc=0x10 → state=HALT, fetch_valid=0, pc=0x10 held for 5 cycles. Then resume → state=RUN, pc=0x10, then 0x11.
- Branch in HALT: in HALT, br_taken with target 0x200 → pc=0x200, flush=1, state stays HALT, fetch_valid stays 0.
- Wrap and async reset: pc=32'hFFFF_FFFF → next pc=0. Assert rst mid-cycle during a jump → pc=RESET_VEC immediately, with no clock edge needed.
